// File: rtl/ipg_msg_arbiter.sv
// ipg_msg_arbiter: shares the single IPG transmit slot between the read-request,
// read-response and write-request message sources. It grants one whole message
// at a time in round-robin order, discards stray non-FIRST blocks while idle,
// and aborts a granted message whose source stops presenting blocks.
module ipg_msg_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [DATA_WIDTH-1:0] rr_data,
  input  logic                  rr_valid,
  output logic                  rr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] ipg_tx_data,
  output logic                  ipg_tx_valid,
  input  logic                  ipg_tx_ready,
  output logic [1:0]            grant_id,
  output logic                  abort,
  output logic [15:0]           drop_cnt
);

  localparam int         CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [1:0] NO_GRANT = 2'd3;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [1:0]            ptr;
  logic [CNT_W-1:0]      starve;

  logic [2:0]            valid;
  logic [2:0]            cand;
  logic [2:0]            stray;
  logic [2:0]            ready;
  logic [2:0]            drop;
  logic [1:0]            win;
  logic [1:0]            idx;
  logic [1:0]            sel;
  logic                  win_found;
  logic                  slot_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [7:0]            sel_type;

  function automatic logic [7:0] first_type(input logic [1:0] id);
    return 8'h0a + {6'd0, id};
  endfunction

  function automatic logic [7:0] last_type(input logic [1:0] id);
    return 8'h2a + {6'd0, id};
  endfunction

  // Round-robin successor over the three requesters.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  function automatic logic [1:0] count3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign valid     = {wr_valid, rr_valid, rd_valid};
  assign slot_free = !ipg_tx_valid || ipg_tx_ready;

  // Classify each presented block as a grant candidate (own FIRST type) or a stray.
  always_comb begin
    cand[0] = rd_valid && (rd_data[7:0] == first_type(2'd0));
    cand[1] = rr_valid && (rr_data[7:0] == first_type(2'd1));
    cand[2] = wr_valid && (wr_data[7:0] == first_type(2'd2));
    stray   = valid & ~cand;
  end

  // First candidate in search order ptr, ptr+1, ptr+2.
  always_comb begin
    win_found = 1'b0;
    win       = ptr;
    idx       = ptr;
    for (int k = 0; k < 3; k++) begin
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
      idx = next_id(idx);
    end
  end

  // Ready generation: strays are swallowed while idle, the winner or owner gets the slot.
  always_comb begin
    ready  = 3'b000;
    drop   = 3'b000;
    accept = 1'b0;
    sel    = win;
    if (!reset) begin
      if (state == IDLE) begin
        ready = stray;
        drop  = stray;
        if (slot_free && win_found) begin
          ready[win] = 1'b1;
          accept     = 1'b1;
        end
      end else begin
        sel             = grant_id;
        ready[grant_id] = slot_free;
        accept          = slot_free && valid[grant_id];
      end
    end
  end

  // Source mux for the block being accepted this cycle.
  always_comb begin
    case (sel)
      2'd0:    sel_data = rd_data;
      2'd1:    sel_data = rr_data;
      default: sel_data = wr_data;
    endcase
    sel_type = sel_data[7:0];
  end

  assign rd_ready = ready[0];
  assign rr_ready = ready[1];
  assign wr_ready = ready[2];

  // Output register: load accepted block, otherwise empty once consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ipg_tx_valid <= 1'b0;
      ipg_tx_data  <= '0;
    end else if (accept) begin
      ipg_tx_valid <= 1'b1;
      ipg_tx_data  <= sel_data;
    end else if (ipg_tx_ready) begin
      ipg_tx_valid <= 1'b0;
    end
  end

  // Grant FSM with starve timer, round-robin pointer and stray-drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= NO_GRANT;
      ptr      <= 2'd0;
      starve   <= '0;
      abort    <= 1'b0;
      drop_cnt <= 16'd0;
    end else begin
      abort    <= 1'b0;
      drop_cnt <= sat_add16(drop_cnt, count3(drop));
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= BUSY;
            grant_id <= win;
            starve   <= '0;
          end
        end
        BUSY: begin
          if (accept) begin
            starve <= '0;
            if (sel_type == last_type(grant_id)) begin
              state    <= IDLE;
              grant_id <= NO_GRANT;
              ptr      <= next_id(grant_id);
            end
          end else if (!valid[grant_id]) begin
            // The edge that brings the count to TIMEOUT is the abort edge.
            if (starve == CNT_W'(TIMEOUT - 1)) begin
              state    <= IDLE;
              grant_id <= NO_GRANT;
              ptr      <= next_id(grant_id);
              abort    <= 1'b1;
              starve   <= '0;
            end else begin
              starve <= starve + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          grant_id <= NO_GRANT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipg_msg_arbiter.sv
// Scoreboard bench for ipg_msg_arbiter: directed messages push their expected
// blocks and grant order into queues; a monitor pops and compares them as the
// DUT presents them.
module tb_ipg_msg_arbiter;
  localparam int DW = 64;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] rd_data, rr_data, wr_data;
  logic          rd_valid, rr_valid, wr_valid;
  logic          rd_ready, rr_ready, wr_ready;
  logic [DW-1:0] ipg_tx_data;
  logic          ipg_tx_valid;
  logic          ipg_tx_ready;
  logic [1:0]    grant_id;
  logic          abort;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  ipg_msg_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rr_data(rr_data), .rr_valid(rr_valid), .rr_ready(rr_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .ipg_tx_data(ipg_tx_data), .ipg_tx_valid(ipg_tx_valid), .ipg_tx_ready(ipg_tx_ready),
    .grant_id(grant_id), .abort(abort), .drop_cnt(drop_cnt)
  );

  int          total = 0;
  int          passed = 0;
  int          abort_cnt = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];
  logic [1:0]  gnt_q[$];
  logic        held_v = 1'b0;
  logic [63:0] held_d = '0;
  logic [1:0]  prev_grant = 2'd3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk(name, act === exp, act, exp);
  endtask

  function automatic logic [63:0] mk(input logic [7:0] tag, input logic [7:0] typ);
    return {48'd0, tag, typ};
  endfunction

  task automatic drive(input int src, input logic v, input logic [63:0] d);
    case (src)
      0: begin rd_valid = v; rd_data = d; end
      1: begin rr_valid = v; rr_data = d; end
      default: begin wr_valid = v; wr_data = d; end
    endcase
  endtask

  function automatic logic rdy(input int src);
    case (src)
      0: return rd_ready;
      1: return rr_ready;
      default: return wr_ready;
    endcase
  endfunction

  // Present one block and hold it until the handshake edge; returns at edge+1.
  task automatic send(input int src, input logic [7:0] tag, input logic [7:0] typ);
    logic got;
    got = 1'b0;
    drive(src, 1'b1, mk(tag, typ));
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = rdy(src);
      @(posedge clk);
      #1;
    end
    if (!got) chk("send_timeout", 1'b0, 64'(src), mk(tag, typ));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ipg_tx_ready = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    drive(2, 1'b0, '0);
    idle(2);
    reset = 1'b0;
  endtask

  // Monitor: consumed blocks, held-data stability, grant order, abort pulses.
  initial forever begin
    @(negedge clk);
    if (ipg_tx_valid === 1'b1 && ipg_tx_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("tx_unexpected", 1'b0, ipg_tx_data, '0);
      else chk_eq("tx_data", ipg_tx_data, exp_q.pop_front());
    end
    if (reset) begin
      held_v     = 1'b0;
      prev_grant = 2'd3;
    end else begin
      if (held_v) begin
        chk_eq("hold_data", ipg_tx_data, held_d);
        chk_eq("hold_valid", 64'(ipg_tx_valid), 64'd1);
      end
      held_v = ipg_tx_valid && !ipg_tx_ready;
      held_d = ipg_tx_data;
      if (grant_id != prev_grant && grant_id != 2'd3) begin
        if (gnt_q.size() == 0) chk("grant_unexpected", 1'b0, 64'(grant_id), 64'd3);
        else chk_eq("grant_order", 64'(grant_id), 64'(gnt_q.pop_front()));
      end
      prev_grant = grant_id;
      if (abort) abort_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    // Reset state, readies forced low during reset.
    reset = 1'b1;
    ipg_tx_ready = 1'b1;
    drive(1, 1'b0, '0);
    drive(2, 1'b0, '0);
    drive(0, 1'b1, mk(8'h00, 8'h0a));
    idle(2);
    @(negedge clk);
    chk_eq("ready_in_reset", 64'(rd_ready), 64'd0);
    chk_eq("rst_tx_valid", 64'(ipg_tx_valid), 64'd0);
    chk_eq("rst_tx_data", ipg_tx_data, 64'd0);
    chk_eq("rst_grant", 64'(grant_id), 64'd3);
    chk_eq("rst_abort", 64'(abort), 64'd0);
    chk_eq("rst_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, '0);
    reset = 1'b0;
    idle(1);

    // Single rr message, back-to-back.
    do_reset();
    exp_q.push_back(mk(8'h01, 8'h0b));
    exp_q.push_back(mk(8'h02, 8'h1b));
    exp_q.push_back(mk(8'h03, 8'h1b));
    exp_q.push_back(mk(8'h04, 8'h2b));
    gnt_q.push_back(2'd1);
    c0 = cyc;
    send(1, 8'h01, 8'h0b);
    send(1, 8'h02, 8'h1b);
    send(1, 8'h03, 8'h1b);
    send(1, 8'h04, 8'h2b);
    drive(1, 1'b0, '0);
    chk_eq("single_cycles", 64'(cyc - c0), 64'd4);
    chk_eq("single_last_out", ipg_tx_data, mk(8'h04, 8'h2b));
    chk_eq("single_grant_end", 64'(grant_id), 64'd3);
    idle(3);
    chk_eq("single_drop", 64'(drop_cnt), 64'd0);

    // Round-robin: all sources contend, rd sends two messages.
    do_reset();
    exp_q.push_back(mk(8'h11, 8'h0a)); exp_q.push_back(mk(8'h12, 8'h1a)); exp_q.push_back(mk(8'h13, 8'h2a));
    exp_q.push_back(mk(8'h21, 8'h0b)); exp_q.push_back(mk(8'h22, 8'h1b)); exp_q.push_back(mk(8'h23, 8'h2b));
    exp_q.push_back(mk(8'h31, 8'h0c)); exp_q.push_back(mk(8'h32, 8'h1c)); exp_q.push_back(mk(8'h33, 8'h2c));
    exp_q.push_back(mk(8'h41, 8'h0a)); exp_q.push_back(mk(8'h42, 8'h1a)); exp_q.push_back(mk(8'h43, 8'h2a));
    gnt_q.push_back(2'd0); gnt_q.push_back(2'd1); gnt_q.push_back(2'd2); gnt_q.push_back(2'd0);
    fork
      begin
        send(0, 8'h11, 8'h0a); send(0, 8'h12, 8'h1a); send(0, 8'h13, 8'h2a);
        send(0, 8'h41, 8'h0a); send(0, 8'h42, 8'h1a); send(0, 8'h43, 8'h2a);
        drive(0, 1'b0, '0);
      end
      begin
        send(1, 8'h21, 8'h0b); send(1, 8'h22, 8'h1b); send(1, 8'h23, 8'h2b);
        drive(1, 1'b0, '0);
      end
      begin
        send(2, 8'h31, 8'h0c); send(2, 8'h32, 8'h1c); send(2, 8'h33, 8'h2c);
        drive(2, 1'b0, '0);
      end
    join
    idle(4);

    // Backpressure on a wr message.
    do_reset();
    exp_q.push_back(mk(8'h51, 8'h0c)); exp_q.push_back(mk(8'h52, 8'h1c));
    exp_q.push_back(mk(8'h53, 8'h1c)); exp_q.push_back(mk(8'h54, 8'h2c));
    gnt_q.push_back(2'd2);
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          ipg_tx_ready = (i % 2 == 0);
          idle(1);
        end
        ipg_tx_ready = 1'b1;
      end
      begin
        send(2, 8'h51, 8'h0c); send(2, 8'h52, 8'h1c);
        send(2, 8'h53, 8'h1c); send(2, 8'h54, 8'h2c);
        drive(2, 1'b0, '0);
      end
    join
    idle(4);
    chk_eq("bp_no_abort", 64'(abort_cnt), 64'd0);

    // Stray drops from two sources in the same idle cycle.
    do_reset();
    drive(0, 1'b1, mk(8'h61, 8'h1a));
    drive(2, 1'b1, mk(8'h62, 8'h2c));
    @(negedge clk);
    chk_eq("stray_rd_ready", 64'(rd_ready), 64'd1);
    chk_eq("stray_wr_ready", 64'(wr_ready), 64'd1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, '0);
    drive(2, 1'b0, '0);
    chk_eq("stray_drop_cnt", 64'(drop_cnt), 64'd2);
    @(negedge clk);
    chk_eq("stray_tx_valid", 64'(ipg_tx_valid), 64'd0);
    chk_eq("stray_grant", 64'(grant_id), 64'd3);
    idle(2);

    // Timeout abort, then the pending rr message is granted.
    do_reset();
    exp_q.push_back(mk(8'h71, 8'h0a));
    exp_q.push_back(mk(8'h72, 8'h0b));
    exp_q.push_back(mk(8'h73, 8'h2b));
    gnt_q.push_back(2'd0);
    gnt_q.push_back(2'd1);
    fork
      begin
        send(0, 8'h71, 8'h0a);
        drive(0, 1'b0, '0);
        for (int c = 1; c <= 5; c++) begin
          @(negedge clk);
          chk_eq("to_abort", 64'(abort), (c == 5) ? 64'd1 : 64'd0);
          if (c == 5) chk_eq("to_grant", 64'(grant_id), 64'd3);
          @(posedge clk);
          #1;
        end
      end
      begin
        send(1, 8'h72, 8'h0b);
        send(1, 8'h73, 8'h2b);
        drive(1, 1'b0, '0);
      end
    join
    idle(4);

    // Reset in the middle of a wr message.
    do_reset();
    exp_q.push_back(mk(8'h81, 8'h0c));
    exp_q.push_back(mk(8'h82, 8'h1c));
    exp_q.push_back(mk(8'h91, 8'h0a));
    exp_q.push_back(mk(8'h92, 8'h2a));
    gnt_q.push_back(2'd2);
    gnt_q.push_back(2'd0);
    send(2, 8'h81, 8'h0c);
    send(2, 8'h82, 8'h1c);
    reset = 1'b1;
    drive(2, 1'b0, '0);
    idle(1);
    chk_eq("mid_rst_valid", 64'(ipg_tx_valid), 64'd0);
    chk_eq("mid_rst_grant", 64'(grant_id), 64'd3);
    chk_eq("mid_rst_drop", 64'(drop_cnt), 64'd0);
    reset = 1'b0;
    send(0, 8'h91, 8'h0a);
    send(0, 8'h92, 8'h2a);
    drive(0, 1'b0, '0);
    idle(5);

    chk_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk_eq("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
    chk_eq("abort_total", 64'(abort_cnt), 64'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
